// File: rtl/store_commit_unit.sv
// store_commit_unit: drains committed stores in order to the D-cache write port or the MMIO bus,
// returning one ack per store. Define STC_MMIO_TIMEOUT_EN to abort stalled MMIO accesses.
package store_commit_pkg;
  localparam int STID_W = 4;
  typedef logic [STID_W-1:0] StID_t;

  typedef struct packed {
    logic        valid;
    StID_t       id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wmask;
    logic        isMMIO;
  } ST_UOp;

  typedef struct packed {
    logic  valid;
    StID_t id;
  } ST_Ack;
endpackage

module store_commit_unit
  import store_commit_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int ID_W         = STID_W,
  parameter int MMIO_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  ST_UOp       IN_uopSt,
  output logic        OUT_stall,
  output logic        OUT_cacheValid,
  output logic [29:0] OUT_cacheAddr,
  output logic [31:0] OUT_cacheData,
  output logic [3:0]  OUT_cacheMask,
  input  logic        IN_cacheReady,
  input  logic        IN_cacheIdle,
  output logic        OUT_mmioReq,
  input  logic        IN_mmioGnt,
  input  logic        IN_mmioDone,
  output ST_Ack       OUT_stAck,
  output logic        OUT_stFault,
  output logic        OUT_busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_CACHE, S_MMIO_REQ, S_MMIO_WAIT, S_FENCE} state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [29:0]     waddr;
    logic [31:0]     data;
    logic [3:0]      wmask;
    logic            is_mmio;
  } entry_t;

  entry_t          fifo_q [FIFO_DEPTH];
  entry_t          head_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, cnt_after;
  state_t          state_q;
  logic            cache_valid_q, mmio_req_q, ack_valid_q;
  logic [ID_W-1:0] ack_id_q;

  entry_t in_entry, nxt;
  logic   push, pop, done, nxt_ok, nxt_cache, load;
  logic   unused_bits;

  assign in_entry = '{id: IN_uopSt.id, waddr: IN_uopSt.addr[31:2], data: IN_uopSt.data,
                      wmask: IN_uopSt.wmask, is_mmio: IN_uopSt.isMMIO};
  assign push = IN_uopSt.valid && !OUT_stall;

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    done = 1'b0;
    case (state_q)
      S_CACHE:     done = IN_cacheReady;
      S_MMIO_WAIT: done = IN_mmioDone;
      S_FENCE:     done = IN_cacheIdle;
      default:     done = 1'b0;
    endcase
  end

`ifdef STC_MMIO_TIMEOUT_EN
  localparam int TMO_W = ($clog2(MMIO_TIMEOUT + 1) > 8) ? $clog2(MMIO_TIMEOUT + 1) : 8;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MMIO_TIMEOUT);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_hit, abort, ack_fault_q;

  // A grant or done in the timeout cycle wins over the abort.
  assign tmo_hit = (tmo_cnt_q == TMO_LIMIT);
  assign abort   = tmo_hit && ((state_q == S_MMIO_REQ  && !IN_mmioGnt) ||
                               (state_q == S_MMIO_WAIT && !IN_mmioDone));
  assign pop     = done || abort;

  // Saturates at the limit so a late grant still leads to an abort in MMIO_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q   <= '0;
      ack_fault_q <= 1'b0;
    end else begin
      ack_fault_q <= abort;
      if (state_q == S_MMIO_REQ || state_q == S_MMIO_WAIT) begin
        if (!tmo_hit) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      end else begin
        tmo_cnt_q <= '0;
      end
    end
  end

  assign OUT_stFault = ack_fault_q;
  assign unused_bits = ^IN_uopSt.addr[1:0];
`else
  assign pop         = done;
  assign OUT_stFault = 1'b0;
  assign unused_bits = ^{IN_uopSt.addr[1:0], MMIO_TIMEOUT[0]};
`endif

  // Candidate for the next access: the entry behind a popping head, or the incoming store
  // when the FIFO would otherwise be empty (gives the t+1 request latency).
  always_comb begin
    cnt_after = count_q - CNT_W'(pop);
    if (cnt_after != '0) begin
      nxt    = fifo_q[rd_ptr_q + PTR_W'(pop)];
      nxt_ok = 1'b1;
    end else begin
      nxt    = in_entry;
      nxt_ok = push;
    end
  end

  assign nxt_cache = nxt_ok && (nxt.wmask != '0) && !nxt.is_mmio;
  assign load      = (state_q == S_IDLE && nxt_ok) ||
                     (state_q == S_CACHE && IN_cacheReady && nxt_cache);

  // NOTE: payload storage carries no reset; count and the valid flags qualify it.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= in_entry;
    if (load) head_q <= nxt;
    if (pop)  ack_id_q <= head_q.id;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cache_valid_q <= 1'b0;
      mmio_req_q    <= 1'b0;
      ack_valid_q   <= 1'b0;
    end else begin
      ack_valid_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      case (state_q)
        S_IDLE: if (nxt_ok) begin
          if (nxt.wmask == '0) begin
            state_q <= S_FENCE;
          end else if (nxt.is_mmio) begin
            state_q    <= S_MMIO_REQ;
            mmio_req_q <= 1'b1;
          end else begin
            state_q       <= S_CACHE;
            cache_valid_q <= 1'b1;
          end
        end
        S_CACHE: if (IN_cacheReady && !nxt_cache) begin
          state_q       <= S_IDLE;
          cache_valid_q <= 1'b0;
        end
        S_MMIO_REQ: if (IN_mmioGnt) begin
          state_q    <= S_MMIO_WAIT;
          mmio_req_q <= 1'b0;
`ifdef STC_MMIO_TIMEOUT_EN
        end else if (abort) begin
          state_q    <= S_IDLE;
          mmio_req_q <= 1'b0;
`endif
        end
        S_MMIO_WAIT: if (pop) state_q <= S_IDLE;
        S_FENCE:     if (IN_cacheIdle) state_q <= S_IDLE;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  assign OUT_stall      = (count_q == FULL);
  assign OUT_cacheValid = cache_valid_q;
  assign OUT_cacheAddr  = head_q.waddr;
  assign OUT_cacheData  = head_q.data;
  assign OUT_cacheMask  = head_q.wmask;
  assign OUT_mmioReq    = mmio_req_q;
  assign OUT_stAck      = '{valid: ack_valid_q, id: ack_id_q};
  assign OUT_busy       = (count_q != '0) || (state_q != S_IDLE);
endmodule
